// File: rtl/interleaver_pingpong_ctrl_if.sv
// rtl/interleaver_pingpong_ctrl_if.sv - interleaver write side, modulator read side and status of the ping-pong controller
interface interleaver_pingpong_ctrl_if #(
  parameter int IW = 8
);
  logic          clr;
  logic          in_valid;
  logic          in_data;
  logic [IW-1:0] in_index;
  logic          in_ready;
  logic          out_ready;
  logic          out_valid;
  logic          out_data;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          overflow;
  logic          index_err;

  modport master (
    output clr, in_valid, in_data, in_index, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, overflow, index_err
  );

  modport slave (
    input  clr, in_valid, in_data, in_index, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, overflow, index_err
  );
endinterface

// File: rtl/interleaver_pingpong_ctrl.sv
// rtl/interleaver_pingpong_ctrl.sv - two-bank ping-pong buffer: permuted-index fill, natural-order drain
module interleaver_pingpong_ctrl #(
  parameter int Ncbps = 192,
  parameter int IW    = $clog2(Ncbps)
) (
  input  logic                          clk,
  input  logic                          reset,
  interleaver_pingpong_ctrl_if.slave    bus
);

  localparam logic [IW-1:0] LAST_IDX = IW'(Ncbps - 1);

  logic [Ncbps-1:0] mem [0:1];

  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic [IW-1:0] wr_cnt;
  logic [IW-1:0] rd_ptr;
  logic          overflow_q;
  logic          index_err_q;

  logic wr_acc;
  logic rd_acc;
  logic wr_done;
  logic rd_done;
  logic idx_ok;

  assign bus.in_ready  = ~full[wr_bank];
  assign bus.out_valid = full[rd_bank];
  assign bus.out_data  = full[rd_bank] ? mem[rd_bank][rd_ptr] : 1'b0;
  assign bus.out_index = rd_ptr;
  assign bus.out_last  = full[rd_bank] && (rd_ptr == LAST_IDX);
  assign bus.overflow  = overflow_q;
  assign bus.index_err = index_err_q;

  assign wr_acc  = bus.in_valid && ~full[wr_bank];
  assign rd_acc  = full[rd_bank] && bus.out_ready;
  assign wr_done = wr_acc && (wr_cnt == LAST_IDX);
  assign rd_done = rd_acc && (rd_ptr == LAST_IDX);
  assign idx_ok  = (bus.in_index <= LAST_IDX);

  // A completing write always targets an empty bank and a completing read a full one,
  // so the set and the clear below never land on the same bit.
  always_comb begin
    full_nxt = full;
    if (rd_done) full_nxt[rd_bank] = 1'b0;
    if (wr_done) full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_acc && idx_ok && !bus.clr) begin
      mem[wr_bank][bus.in_index] <= bus.in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      index_err_q <= 1'b0;
    end else if (bus.clr) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      index_err_q <= 1'b0;
    end else begin
      full <= full_nxt;
      if (bus.in_valid && full[wr_bank]) begin
        overflow_q <= 1'b1;
      end
      if (wr_acc) begin
        if (!idx_ok) index_err_q <= 1'b1;
        if (wr_done) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_acc) begin
        if (rd_done) begin
          rd_ptr  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_interleaver_pingpong_ctrl.sv
// tb/tb_interleaver_pingpong_ctrl.sv - scoreboard bench for the ping-pong interleaver buffer
module tb_interleaver_pingpong_ctrl;
  localparam int NC = 192;
  localparam int IW = 8;

  logic clk;
  logic reset;

  interleaver_pingpong_ctrl_if #(.IW(IW)) bus ();

  interleaver_pingpong_ctrl #(.Ncbps(NC), .IW(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit q_d[$];
  bit blkbuf[NC];
  int wcnt   = 0;
  int rdexp  = 0;
  bit ovf_e  = 0;
  bit ierr_e = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int perm(input int k);
    return (k % 16) * 12 + k / 16;
  endfunction

  task automatic model_reset();
    q_d.delete();
    wcnt   = 0;
    rdexp  = 0;
    ovf_e  = 0;
    ierr_e = 0;
  endtask

  task automatic cyc(input bit iv, input bit id, input int ix, input bit ordy);
    bit exp_rdy;
    bit exp_vld;
    bus.clr       = 1'b0;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.in_index  = ix[IW-1:0];
    bus.out_ready = ordy;
    #1;
    exp_rdy = (q_d.size() <= NC);
    exp_vld = (q_d.size() != 0);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, exp_vld);
    chk("overflow", bus.overflow, ovf_e);
    chk("index_err", bus.index_err, ierr_e);
    if (exp_vld) begin
      chk("out_data", bus.out_data, q_d[0]);
      chk("out_index", bus.out_index, rdexp);
      chk("out_last", bus.out_last, rdexp == NC - 1);
      if (ordy) begin
        void'(q_d.pop_front());
        rdexp = (rdexp == NC - 1) ? 0 : rdexp + 1;
      end
    end else begin
      chk("idle_data", bus.out_data, 0);
      chk("idle_last", bus.out_last, 0);
    end
    if (iv && !exp_rdy) ovf_e = 1;
    if (iv && exp_rdy) begin
      if (ix < NC) blkbuf[ix] = id;
      else ierr_e = 1;
      wcnt++;
      if (wcnt == NC) begin
        for (int i = 0; i < NC; i++) q_d.push_back(blkbuf[i]);
        wcnt = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_block(input bit ordy, input bit rnd);
    for (int k = 0; k < NC; k++) begin
      bit d;
      d = rnd ? bit'($urandom_range(1, 0)) : bit'(k % 2);
      cyc(1'b1, d, perm(k), ordy);
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, ordy);
  endtask

  task automatic do_clr();
    bus.clr       = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.clr = 1'b0;
    model_reset();
  endtask

  initial begin
    bus.clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 1'b0;
    bus.in_index  = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_index", bus.out_index, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_index_err", bus.index_err, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // single block, data = k[0], drained with out_ready held high
    wr_block(1'b1, 1'b0);
    idle(NC + 2, 1'b1);

    // four back-to-back blocks, continuous in_valid
    for (int b = 0; b < 4; b++) wr_block(1'b1, 1'b1);
    idle(NC + 2, 1'b1);

    // backpressure: two full banks, then one dropped write
    wr_block(1'b0, 1'b1);
    wr_block(1'b0, 1'b1);
    cyc(1'b1, 1'b1, 0, 1'b0);
    chk("ovf_set", bus.overflow, 1);
    idle(2 * NC + 2, 1'b1);

    // out-of-range index advances wr_cnt and sets index_err
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, k, 1'b0);
    cyc(1'b1, 1'b1, 200, 1'b0);
    chk("ierr_set", bus.index_err, 1);
    chk("wr_cnt_adv", dut.wr_cnt, 6);
    do_clr();
    idle(2, 1'b0);

    // write completion of bank 1 coincides with read completion of bank 0
    wr_block(1'b0, 1'b1);
    for (int k = 0; k < NC - 1; k++) cyc(1'b1, bit'($urandom_range(1, 0)), perm(k), 1'b1);
    chk("full_before", dut.full, 2'b01);
    cyc(1'b1, 1'b1, perm(NC - 1), 1'b1);
    chk("full_after", dut.full, 2'b10);
    chk("rd_bank_after", dut.rd_bank, 1);
    idle(NC + 2, 1'b1);

    // async reset in the middle of a drain
    wr_block(1'b0, 1'b1);
    idle(57, 1'b1);
    chk("rd_ptr_57", dut.rd_ptr, 57);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_out_index", bus.out_index, 0);
    chk("async_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    wr_block(1'b0, 1'b1);
    chk("post_rst_rd_bank", dut.rd_bank, 0);
    chk("post_rst_full", dut.full, 2'b01);
    idle(NC + 2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
